// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks one completed functional-unit result per cycle and
// registers it onto the common data bus snooped by the ROB and stations.
// Build option: define CDB_ARB_ROUND_ROBIN_EN for round-robin selection;
// without it the lowest valid index always wins and no pointer exists.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      cdb_ready,
  input  logic                      flush,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

  logic              free;
  logic              grant;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

`ifdef CDB_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] last_q, last_d;

  // Search last+1, last+2, ... with an explicit wrap, since NUM_REQ may not be a power of two
  always_comb begin
    logic [PTR_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = last_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Pointer only moves on an actual grant, so a flush leaves the rotation intact
  always_comb begin
    last_d = grant ? win_idx : last_q;
  end

  // Pointer register; reset value makes requester 0 the first winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= LAST_IDX;
    else      last_q <= last_d;
  end
`else
  // Fixed priority: lowest valid index wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
  end
`endif

  // Output slot can take a new result when empty or being consumed this cycle.
  // Grants are held off during reset so nothing transfers that the register cannot capture.
  assign free  = !cdb_valid_q || cdb_ready;
  assign grant = rst && free && !flush && win_found;

  // One-hot grant and winner payload mux; grant depends only on valid/control, never on payload
  always_comb begin
    req_ready = '0;
    sel_tag   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        req_ready[i] = grant;
        sel_tag      = req_tag[i*TAG_W +: TAG_W];
        sel_data     = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register next state: flush beats grant and hold; payload is only rewritten on grant
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (grant) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = sel_tag;
      cdb_data_d  = sel_data;
    end else if (free) begin
      cdb_valid_d = 1'b0;
    end
  end

  // CDB output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbiter and output stage for the common data bus of the Tomasulo core. Functional units (ALU reservation-station pipes, load unit, branch/jump unit) each present one completed result as a ROB tag plus 32-bit data. The block grants at most one requester per cycle and registers the winner onto the CDB. The ROB and all reservation stations snoop the CDB. The block applies ROB backpressure and supports a flush on branch mispredict.

## Interface
Parameters:
- NUM_REQ, 4, number of functional-unit requesters (2..8)
- TAG_W, 3, ROB tag width (8 ROB entries)
- DATA_W, 32, result data width (matches cdb_data)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i holds a completed result
- req_tag  in  NUM_REQ*TAG_W  ROB tag of requester i; slice i at [i*TAG_W +: TAG_W]
- req_data  in  NUM_REQ*DATA_W  result of requester i; slice i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant, combinational; the result transfers when req_valid[i] & req_ready[i]
- cdb_ready  in  1  ROB accepts the current broadcast this cycle
- flush  in  1  mispredict flush; drops the pending broadcast and suppresses grants
- cdb_valid  out  1  CDB carries a valid result
- cdb_tag  out  TAG_W  broadcast ROB tag
- cdb_data  out  DATA_W  broadcast result data

## Operation
- Output register (cdb_valid/tag/data) is "free" when !cdb_valid || cdb_ready.
- Grant rule: when free && !flush && |req_valid, exactly one req_ready bit is asserted, for the selected requester. Otherwise req_ready = 0.
- On grant, the output register loads the winner's tag and data, and cdb_valid <= 1.
- When free with no grant, cdb_valid <= 0.
- When not free (cdb_valid && !cdb_ready), the output register holds tag and data unchanged.
- Requesters must keep valid, tag and data stable until granted. The arbiter never drops or duplicates a result.
- flush: cdb_valid <= 0 next edge, req_ready = 0 this cycle. The round-robin pointer is unchanged. Requesters discard their own in-flight results.
- Selection (round-robin, see Configuration):
  - A pointer last holds the most recently granted index.
  - The search order is last+1, last+2, … mod NUM_REQ. The first valid index wins.
  - last updates to the winner only on a grant.
- Arithmetic: pointer width is clog2(NUM_REQ). The wrap from NUM_REQ-1 to 0 is explicit, because NUM_REQ need not be a power of 2.
- Simultaneous accept and grant: if cdb_ready=1 while cdb_valid=1, a new winner loads in the same edge. This sustains 1 broadcast/cycle.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, last=NUM_REQ-1 (requester 0 wins first).
- req_ready is combinational only from req_valid, cdb_valid, cdb_ready, flush and last. It has no path from req_tag or req_data.
- Latency: 1 cycle. A grant in cycle N drives cdb_valid/tag/data in cycle N+1.
- Throughput: 1 result/cycle while cdb_ready=1.
- A reset asserted mid-broadcast clears the output immediately (asynchronous). Grants resume on the first edge after deassertion.
- flush has priority over grant and over hold. flush together with cdb_ready=0 still clears cdb_valid.

## Configuration
- CDB_ARB_ROUND_ROBIN_EN defined: round-robin selection as above. Every requester with valid held is granted within NUM_REQ grants.
- Undefined: fixed priority, lowest index wins. The pointer register is not instantiated. Starvation of high indices is accepted.

## Test plan
- Reset: hold rst=0 with req_valid=4'b1111 -> cdb_valid=0, req_ready=0. Release rst -> req_ready=4'b0001. Next cycle cdb_tag=req 0's tag.
- Round-robin: all four requesters valid with tags 1,2,3,4, cdb_ready=1 -> grants in order 0,1,2,3,0. CDB shows tags 1,2,3,4,1 on consecutive cycles with no bubbles. With the macro undefined -> requester 0 is granted every cycle.
- Backpressure: cdb_valid with tag 5/data 0xDEADBEEF, cdb_ready=0 for 3 cycles, req 2 valid -> output holds 5/0xDEADBEEF and req_ready=0 for 3 cycles. On cdb_ready=1, req 2 is granted in the same cycle and appears next cycle.
- Flush: flush=1 while cdb_valid=1 and req 1 valid -> req_ready=0 that cycle and cdb_valid=0 next cycle. After flush drops, req 1 is granted and the pointer order continues from before the flush.
- Wrap with NUM_REQ=3: last=2, req_valid=3'b101 -> requester 0 is granted, then requester 2.
- Sparse requests: single requester 3 valid with data 0x00000010 -> granted immediately. cdb_data=0x10 for exactly one cycle, then cdb_valid=0.
